// File: rtl/obi2ahb_mux_if.sv
// Bundle of the OBI data-port and AHB3-lite multi-slave signals for obi2ahb_mux.
// The master modport is the bridge's view; the slave modport is the view of
// the surrounding core and slaves.
interface obi2ahb_mux_if #(
    parameter int unsigned NUM_SLV = 4
);
    // OBI data port
    logic                    data_req_i;
    logic                    data_gnt_o;
    logic                    data_rvalid_o;
    logic                    data_we_i;
    logic [3:0]              data_be_i;
    logic [31:0]             data_addr_i;
    logic [31:0]             data_wdata_i;
    logic [31:0]             data_rdata_o;
    logic                    data_err_o;

    // AHB3-lite shared master signals
    logic [NUM_SLV-1:0]      HSEL;
    logic [31:0]             HADDR;
    logic                    HWRITE;
    logic [2:0]              HSIZE;
    logic [1:0]              HTRANS;
    logic [31:0]             HWDATA;
    logic                    HREADY;

    // AHB3-lite per-slave responses
    logic [NUM_SLV*32-1:0]   HRDATA;
    logic [NUM_SLV-1:0]      HREADYOUT;
    logic [NUM_SLV-1:0]      HRESP;

    logic                    bus_err_o;

    modport master (
        input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
        output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
        output HSEL, HADDR, HWRITE, HSIZE, HTRANS, HWDATA, HREADY,
        input  HRDATA, HREADYOUT, HRESP,
        output bus_err_o
    );

    modport slave (
        output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
        input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
        input  HSEL, HADDR, HWRITE, HSIZE, HTRANS, HWDATA, HREADY,
        output HRDATA, HREADYOUT, HRESP,
        input  bus_err_o
    );
endinterface

// File: rtl/obi2ahb_mux.sv
// OBI data-port to AHB3-lite bridge with an integrated address decoder and
// response mux for up to 8 slaves. One outstanding transfer at a time; illegal
// accesses, decode misses and data-phase timeouts complete with an error response.
module obi2ahb_mux #(
    parameter int unsigned           NUM_SLV  = 4,
    parameter logic [NUM_SLV*32-1:0] SLV_BASE = {32'h0003_0000, 32'h0002_0000,
                                                 32'h0001_0000, 32'h0000_0000},
    parameter logic [NUM_SLV*32-1:0] SLV_MASK = {4{32'hFFFF_0000}},
    parameter int unsigned           TIMEOUT  = 256
) (
    input  logic                 clk_sys,
    input  logic                 rst_sys_n,
    obi2ahb_mux_if.master        bus
);

    localparam int unsigned IDX_W   = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
    localparam logic [31:0] TO_LAST = (TIMEOUT == 0) ? 32'd0 : TIMEOUT - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        ERR  = 2'd3
    } state_t;

    state_t             state_q, state_d;

    // Captured request
    logic [31:0]        addr_q;
    logic               we_q;
    logic [2:0]         size_q;
    logic [31:0]        wdata_q;
    logic [IDX_W-1:0]   sel_q;

    // Response and timeout registers
    logic               rvalid_q, rvalid_d;
    logic               err_q, err_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               bus_err_q;
    logic [31:0]        tcnt_q, tcnt_d;

    logic               gnt;
    logic               capture;

    // Byte-enable derived transfer shape
    logic [2:0]         be_size;
    logic [1:0]         be_low;
    logic               be_legal;

    // Address decode
    logic               hit;
    logic [IDX_W-1:0]   hit_idx;

    // Selected-slave response view
    logic [31:0]        sel_rdata;
    logic               sel_ready;
    logic               sel_resp;
    logic [NUM_SLV-1:0] sel_onehot;

    // Map byte enables to HSIZE and the low address bits; odd write patterns are illegal
    always_comb begin
        be_size  = 3'd2;
        be_low   = 2'b00;
        be_legal = !bus.data_we_i;
        case (bus.data_be_i)
            4'b1111: begin be_size = 3'd2; be_low = 2'b00; be_legal = 1'b1; end
            4'b0011: begin be_size = 3'd1; be_low = 2'b00; be_legal = 1'b1; end
            4'b1100: begin be_size = 3'd1; be_low = 2'b10; be_legal = 1'b1; end
            4'b0001: begin be_size = 3'd0; be_low = 2'b00; be_legal = 1'b1; end
            4'b0010: begin be_size = 3'd0; be_low = 2'b01; be_legal = 1'b1; end
            4'b0100: begin be_size = 3'd0; be_low = 2'b10; be_legal = 1'b1; end
            4'b1000: begin be_size = 3'd0; be_low = 2'b11; be_legal = 1'b1; end
            default: ;
        endcase
    end

    // Decode the request address; the lowest matching slave index wins
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int unsigned i = 0; i < NUM_SLV; i++) begin
            if (!hit && ((bus.data_addr_i & SLV_MASK[i*32 +: 32]) == SLV_BASE[i*32 +: 32])) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    // Mux the response of the captured slave and build its one-hot select
    always_comb begin
        sel_rdata  = '0;
        sel_ready  = 1'b0;
        sel_resp   = 1'b0;
        sel_onehot = '0;
        for (int unsigned i = 0; i < NUM_SLV; i++) begin
            if (sel_q == IDX_W'(i)) begin
                sel_rdata     = bus.HRDATA[i*32 +: 32];
                sel_ready     = bus.HREADYOUT[i];
                sel_resp      = bus.HRESP[i];
                sel_onehot[i] = 1'b1;
            end
        end
    end

    // Next-state, grant and response generation
    always_comb begin
        state_d  = state_q;
        gnt      = 1'b0;
        capture  = 1'b0;
        rvalid_d = 1'b0;
        err_d    = 1'b0;
        rdata_d  = '0;
        tcnt_d   = '0;
        case (state_q)
            IDLE: begin
                gnt = bus.data_req_i;
                if (bus.data_req_i) begin
                    capture = 1'b1;
                    state_d = (hit && be_legal) ? ADDR : ERR;
                end
            end
            ADDR: state_d = DATA;
            DATA: begin
                // HRESP is only meaningful when HREADYOUT is high, which
                // naturally skips the first cycle of a two-cycle ERROR
                if (sel_ready) begin
                    rvalid_d = 1'b1;
                    err_d    = sel_resp;
                    rdata_d  = we_q ? '0 : sel_rdata;
                    state_d  = IDLE;
                end else if ((TIMEOUT != 0) && (tcnt_q == TO_LAST)) begin
                    rvalid_d = 1'b1;
                    err_d    = 1'b1;
                    state_d  = IDLE;
                end else if (TIMEOUT != 0) begin
                    tcnt_d = tcnt_q + 32'd1;
                end
            end
            ERR: begin
                rvalid_d = 1'b1;
                err_d    = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk_sys) begin
        if (!rst_sys_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request capture, response and timeout registers
    always_ff @(posedge clk_sys) begin
        if (!rst_sys_n) begin
            addr_q    <= '0;
            we_q      <= 1'b0;
            size_q    <= '0;
            wdata_q   <= '0;
            sel_q     <= '0;
            rvalid_q  <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
            bus_err_q <= 1'b0;
            tcnt_q    <= '0;
        end else begin
            rvalid_q  <= rvalid_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
            bus_err_q <= rvalid_d & err_d;
            tcnt_q    <= tcnt_d;
            if (capture) begin
                addr_q  <= {bus.data_addr_i[31:2], be_low};
                we_q    <= bus.data_we_i;
                size_q  <= be_size;
                wdata_q <= bus.data_wdata_i;
                sel_q   <= hit_idx;
            end
        end
    end

    // Grant is combinational in IDLE but suppressed while reset is held
    assign bus.data_gnt_o    = gnt & rst_sys_n;
    assign bus.data_rvalid_o = rvalid_q;
    assign bus.data_rdata_o  = rdata_q;
    assign bus.data_err_o    = err_q;
    assign bus.bus_err_o     = bus_err_q;

    assign bus.HSEL   = (state_q == ADDR) ? sel_onehot : '0;
    assign bus.HTRANS = (state_q == ADDR) ? 2'b10 : 2'b00;
    assign bus.HADDR  = addr_q;
    assign bus.HWRITE = we_q;
    assign bus.HSIZE  = size_q;
    assign bus.HWDATA = wdata_q;
    assign bus.HREADY = (state_q == DATA) ? sel_ready : 1'b1;

endmodule
